// File: rtl/bip_run_ctrl.sv
// UART command sequencer for the BIP: loads program words, runs the core under a watchdog,
// then streams the first data-memory words back to the host.
module bip_run_ctrl #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DUMP_WORDS = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    input  logic              halt,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wr_pm,
    output logic              rd_dm,
    output logic              bip_reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        status
);

    localparam int unsigned CYC_W = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W = 9;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StLdCnt   = 4'd1,
        StLdHi    = 4'd2,
        StLdLo    = 4'd3,
        StLdWr    = 4'd4,
        StRun     = 4'd5,
        StWait    = 4'd6,
        StDumpRd  = 4'd7,
        StDumpCap = 4'd8,
        StDumpLo  = 4'd9
    } state_t;

    state_t            state;
    state_t            ret_state;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] word_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [IDX_W-1:0]  dump_idx;
    logic [7:0]        dump_lo;
    logic              running;
    logic              halted;
    logic              timed_out;
    logic              loaded;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            ret_state <= StIdle;
            word_idx  <= '0;
            word_cnt  <= '0;
            cyc_cnt   <= '0;
            dump_idx  <= '0;
            dump_lo   <= '0;
            running   <= 1'b0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            loaded    <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            wr_pm     <= 1'b0;
            rd_dm     <= 1'b0;
            bip_reset <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            status    <= '0;
        end else begin
            tx_start <= 1'b0;
            wr_pm    <= 1'b0;
            rd_dm    <= 1'b0;
            status   <= {state, running, halted, timed_out, loaded};
            case (state)
                StIdle: begin
                    if (rx_done) begin
                        if (rx_data == 8'h4C) begin
                            state <= StLdCnt;
                        end else if (rx_data == 8'h52) begin
                            halted    <= 1'b0;
                            timed_out <= 1'b0;
                            running   <= 1'b1;
                            bip_reset <= 1'b0;
                            cyc_cnt   <= '0;
                            state     <= StRun;
                        end else begin
                            tx_start  <= 1'b1;
                            tx_data   <= 8'h3F;
                            ret_state <= StIdle;
                            state     <= StWait;
                        end
                    end
                end
                StLdCnt: begin
                    if (rx_done) begin
                        // A count byte of zero stands for a full 256-word image.
                        word_cnt <= (rx_data == 8'd0) ? ADDR_W'(256) : ADDR_W'(rx_data);
                        word_idx <= '0;
                        state    <= StLdHi;
                    end
                end
                StLdHi: begin
                    if (rx_done) begin
                        mem_wdata[DATA_W-1 -: 8] <= rx_data;
                        state                    <= StLdLo;
                    end
                end
                StLdLo: begin
                    if (rx_done) begin
                        mem_wdata[7:0] <= rx_data;
                        mem_addr       <= word_idx;
                        wr_pm          <= 1'b1;
                        state          <= StLdWr;
                    end
                end
                StLdWr: begin
                    word_idx <= word_idx + ADDR_W'(1);
                    if ((word_idx + ADDR_W'(1)) == word_cnt) begin
                        loaded    <= 1'b1;
                        tx_start  <= 1'b1;
                        tx_data   <= 8'h4B;
                        ret_state <= StIdle;
                        state     <= StWait;
                    end else begin
                        state <= StLdHi;
                    end
                end
                StRun: begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                    // Halt takes priority over a watchdog expiry in the same cycle.
                    if (halt || (cyc_cnt == CYC_W'(TIMEOUT - 1))) begin
                        bip_reset <= 1'b1;
                        running   <= 1'b0;
                        halted    <= halt;
                        timed_out <= !halt;
                        tx_start  <= 1'b1;
                        tx_data   <= halt ? 8'h48 : 8'h54;
                        dump_idx  <= '0;
                        ret_state <= StDumpRd;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (tx_done) begin
                        state <= ret_state;
                        if (ret_state == StDumpRd) begin
                            rd_dm    <= 1'b1;
                            mem_addr <= ADDR_W'(dump_idx);
                        end
                    end
                end
                StDumpRd: begin
                    state <= StDumpCap;
                end
                StDumpCap: begin
                    dump_lo   <= dm_rdata[7:0];
                    tx_start  <= 1'b1;
                    tx_data   <= dm_rdata[DATA_W-1 -: 8];
                    ret_state <= StDumpLo;
                    state     <= StWait;
                end
                StDumpLo: begin
                    tx_start  <= 1'b1;
                    tx_data   <= dump_lo;
                    dump_idx  <= dump_idx + IDX_W'(1);
                    ret_state <= (dump_idx == IDX_W'(DUMP_WORDS - 1)) ? StIdle : StDumpRd;
                    state     <= StWait;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed bench for bip_run_ctrl: UART, BIP and data-memory models around the DUT, with
// table-driven command, load and run vectors.
module tb_bip_run_ctrl;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DUMP_WORDS = 2;
    localparam int unsigned TIMEOUT    = 20;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        halt;
    logic [15:0] dm_rdata;
    logic        wr_pm;
    logic        rd_dm;
    logic        bip_reset;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [7:0]  status;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq[$];
    int          low_total = 0;
    int          wr_total = 0;
    int          halt_at = 0;
    logic [15:0] pc;
    logic [15:0] dm[16];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] reply;
    } cmd_vec_t;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] addr;
        logic [15:0] data;
    } ld_vec_t;

    typedef struct {
        int         halt_at;
        int         low;
        logic [7:0] reply;
        logic [3:0] flags;
    } run_vec_t;

    bip_run_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DUMP_WORDS (DUMP_WORDS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .halt      (halt),
        .dm_rdata  (dm_rdata),
        .wr_pm     (wr_pm),
        .rd_dm     (rd_dm),
        .bip_reset (bip_reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .status    (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BIP model: halts in its halt_at-th cycle out of reset.
    always @(posedge clk) begin
        if (bip_reset) pc <= '0;
        else           pc <= pc + 16'd1;
    end
    assign halt = !bip_reset && (halt_at != 0) && (pc == 16'(halt_at - 1));

    always @(posedge clk) begin
        if (rd_dm) dm_rdata <= dm[mem_addr[3:0]];
    end

    always @(negedge clk) begin
        if (!bip_reset) low_total++;
        if (wr_pm)      wr_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // UART transmitter model: records each byte and answers tx_done a few cycles later.
    initial begin
        logic [7:0] got;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                got = tx_data;
                txq.push_back(got);
                repeat (3) begin
                    @(negedge clk);
                    chk("tx_hold", {tx_start, tx_data}, {1'b0, got});
                end
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int budget = 400;
        while (txq.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(name, 32'(txq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int budget = 400;
        repeat (2) @(negedge clk);
        while (status[7:4] != 4'd0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("idle", 32'(status[7:4]), 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_wr_pm", 32'(wr_pm), 32'd0);
        chk("rst_rd_dm", 32'(rd_dm), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_bip_reset", 32'(bip_reset), 32'd1);
    endtask

    task automatic run_case(input int ha, input int exp_low, input logic [7:0] exp_reply,
                            input logic [3:0] exp_flags);
        int base = txq.size();
        int lo0  = low_total;
        int wr0  = wr_total;
        halt_at = ha;
        send_byte(8'h52);
        send_byte(8'h4C);  // ignored while running
        send_byte(8'h03);
        @(negedge clk);
        chk("run_status", 32'(status[7:3]), 32'h0B);
        wait_tx(base + 1, "reply_tx");
        chk("reply", 32'(txq[base]), 32'(exp_reply));
        send_byte(8'h7A);  // ignored while dumping
        wait_tx(base + 1 + 2 * DUMP_WORDS, "dump_tx");
        for (int i = 0; i < DUMP_WORDS; i++) begin
            chk("dump_hi", 32'(txq[base + 1 + 2 * i]), 32'(dm[i][15:8]));
            chk("dump_lo", 32'(txq[base + 2 + 2 * i]), 32'(dm[i][7:0]));
        end
        wait_idle();
        repeat (10) @(negedge clk);
        chk("tx_count", 32'(txq.size() - base), 32'(1 + 2 * DUMP_WORDS));
        chk("run_len", 32'(low_total - lo0), 32'(exp_low));
        chk("no_wr", 32'(wr_total - wr0), 32'd0);
        chk("flags", 32'(status[3:0]), 32'(exp_flags));
        halt_at = 0;
    endtask

    cmd_vec_t cmd_tab[3];
    ld_vec_t  ld_tab[3];
    run_vec_t run_tab[3];

    initial begin
        int         base;
        int         wr0;
        logic [7:0] hi;
        logic [7:0] lo;

        cmd_tab[0] = '{cmd: 8'h7A, reply: 8'h3F};
        cmd_tab[1] = '{cmd: 8'h00, reply: 8'h3F};
        cmd_tab[2] = '{cmd: 8'h4B, reply: 8'h3F};
        ld_tab[0]  = '{hi: 8'h12, lo: 8'h34, addr: 12'd0, data: 16'h1234};
        ld_tab[1]  = '{hi: 8'hAB, lo: 8'hCD, addr: 12'd1, data: 16'hABCD};
        ld_tab[2]  = '{hi: 8'h00, lo: 8'h01, addr: 12'd2, data: 16'h0001};
        run_tab[0] = '{halt_at: 10, low: 10, reply: 8'h48, flags: 4'b0101};
        run_tab[1] = '{halt_at: 0,  low: 20, reply: 8'h54, flags: 4'b0011};
        run_tab[2] = '{halt_at: 20, low: 20, reply: 8'h48, flags: 4'b0101};

        for (int i = 0; i < 16; i++) dm[i] = 16'(i * 257);
        dm[0] = 16'h00FF;
        dm[1] = 16'h1234;

        reset   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            base = txq.size();
            send_byte(cmd_tab[i].cmd);
            wait_tx(base + 1, "bad_cmd_tx");
            chk("bad_cmd_reply", 32'(txq[base]), 32'(cmd_tab[i].reply));
            wait_idle();
        end

        base = txq.size();
        wr0  = wr_total;
        send_byte(8'h4C);
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(ld_tab[i].hi);
            send_byte(ld_tab[i].lo);
            @(negedge clk);
            chk("ld_wr", {wr_pm, mem_addr, mem_wdata}, {1'b1, ld_tab[i].addr, ld_tab[i].data});
            @(negedge clk);
            chk("ld_wr_pulse", 32'(wr_pm), 32'd0);
        end
        wait_tx(base + 1, "ld_ack_tx");
        chk("ld_ack", 32'(txq[base]), 32'h4B);
        wait_idle();
        chk("ld_loaded", 32'(status[0]), 32'd1);
        chk("ld_wr_count", 32'(wr_total - wr0), 32'd3);

        for (int i = 0; i < 3; i++) begin
            run_case(run_tab[i].halt_at, run_tab[i].low, run_tab[i].reply, run_tab[i].flags);
        end

        base = txq.size();
        send_byte(8'h4C);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            hi = 8'(i) ^ 8'hA5;
            lo = 8'(i);
            send_byte(hi);
            send_byte(lo);
            @(negedge clk);
            chk("ld256_wr", {wr_pm, mem_addr, mem_wdata}, {1'b1, 12'(i), hi, lo});
        end
        wait_tx(base + 1, "ld256_ack_tx");
        chk("ld256_ack", 32'(txq[base]), 32'h4B);
        wait_idle();

        // Reset in the middle of a three-word load.
        send_byte(8'h4C);
        send_byte(8'h03);
        send_byte(8'h55);
        send_byte(8'hAA);
        @(negedge clk);
        chk("abort_wr", {wr_pm, mem_wdata}, {1'b1, 16'h55AA});
        base = txq.size();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_reply", 32'(txq.size() - base), 32'd0);
        chk("abort_idle", 32'(status), 32'd0);
        run_case(5, 5, 8'h48, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bip_run_ctrl.md
# bip_run_ctrl

UART-driven load/run/dump sequencer for the BIP processor. It sits between the UART byte interface and the BIP memory/reset controls. It parses single-byte commands from the host, writes received 16-bit words into program memory, and releases the BIP from reset until it halts or a watchdog expires. It then streams the first data-memory words back to the host.

## Interface
Parameters:
- ADDR_W, 12: memory address width.
- DATA_W, 16: memory word width; fixed at 2 UART bytes.
- DUMP_WORDS, 16: DM words returned after a run (1..256).
- TIMEOUT, 4096: maximum run cycles before forced stop (≥1).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- rx_data  in  8  received byte, valid when rx_done=1.
- rx_done  in  1  1-cycle pulse per received byte.
- tx_data  out  8  byte to send; held stable from tx_start until tx_done.
- tx_start  out  1  1-cycle pulse launching a UART transmit.
- tx_done  in  1  1-cycle pulse when the UART finishes a byte.
- halt  in  1  BIP executed halt (level).
- dm_rdata  in  DATA_W  DM read data, valid 1 cycle after rd_dm.
- wr_pm  out  1  PM write strobe, 1 cycle.
- rd_dm  out  1  DM read strobe, 1 cycle.
- bip_reset  out  1  high holds the BIP in reset. The memory port follows mem_addr only while this is high.
- mem_addr  out  ADDR_W  PM/DM address.
- mem_wdata  out  DATA_W  PM write data.
- status  out  8  LED status: {state[3:0], running, halted, timed_out, loaded}.

## Operation
- Reset values:
  - tx_start=0, tx_data=0, wr_pm=0, rd_dm=0, mem_addr=0, mem_wdata=0, status=0.
  - bip_reset=1.
  - State IDLE, all flags 0.
- IDLE: on rx_done, decode rx_data:
  - 0x4C 'L' → LD_CNT.
  - 0x52 'R' → RUN. Clears halted/timed_out; sets running.
  - Anything else → send 0x3F '?', then back to IDLE.
- LD_CNT: the next byte is word count N; N=0 means 256. Clear the address counter, then go to LD_HI.
- LD_HI / LD_LO: each captures one byte, high byte first, assembling mem_wdata.
- LD_WR: one cycle with wr_pm=1, mem_addr=word index, mem_wdata=assembled word.
  - Then increment the index.
  - If index==N, set loaded and send 0x4B 'K'; otherwise go to LD_HI.
- RUN:
  - bip_reset=0; the cycle counter increments each RUN cycle.
  - Exit on the first cycle with halt=1 (reply 0x48 'H', set halted), or when the counter reaches TIMEOUT (reply 0x54 'T', set timed_out).
  - If both occur in the same cycle, halt wins.
  - On exit: bip_reset=1 from the next cycle, running cleared. After the reply completes, go to DUMP.
- DUMP, for i = 0..DUMP_WORDS-1:
  - DUMP_RD: rd_dm=1 with mem_addr=i.
  - DUMP_CAP: latch dm_rdata.
  - Send the high byte, then the low byte. Each byte is a tx_start pulse followed by a wait for tx_done.
  - After the last word, return to IDLE.
- Send sub-sequence: pulse tx_start for 1 cycle with tx_data set, then wait in the WAIT state until tx_done.
- rx_done is ignored in every state except IDLE, LD_CNT, LD_HI and LD_LO. Bytes arriving during RUN, DUMP or any send are dropped.
- tx_done outside a WAIT state is ignored.
- The cycle counter width is the minimum that holds TIMEOUT. The word index is ADDR_W bits; N≤256 never wraps.
- Async reset mid-operation:
  - Aborts immediately to IDLE with bip_reset=1.
  - Any partial load stays in PM; no reply is sent.

## Timing
- Command byte rx_done in cycle t → new state in t+1.
- LD_LO rx_done at t → wr_pm high in cycle t+1 only.
- Reply tx_start: one cycle after the decision cycle.
- Run length: bip_reset low for exactly k cycles when halt is first seen in the k-th RUN cycle. Timeout gives exactly TIMEOUT low cycles.
- DM read: rd_dm at t, dm_rdata sampled at t+1; the high-byte tx_start follows at t+2.
- Per-byte throughput is limited by UART tx_done. The controller adds 1 cycle between tx_done and the next tx_start.
- status updates one cycle after the state change; state[3:0] holds the encoded FSM state.

## Test plan
- Load test:
  - Stimulus: 0x4C, 0x03, then 0x12 0x34, 0xAB 0xCD, 0x00 0x01.
  - Response: three single-cycle wr_pm at addr 0/1/2 with data 0x1234/0xABCD/0x0001, then tx 0x4B, then loaded=1.
- Run-to-halt test:
  - Stimulus: 0x52, with halt asserted on the 10th RUN cycle.
  - Response: bip_reset low exactly 10 cycles, then tx 0x48, then 2×DUMP_WORDS bytes high-first. With DM[0]=0x00FF the first dump bytes are 0x00, 0xFF.
- Watchdog test:
  - Stimulus: TIMEOUT=20 and halt held low.
  - Response: bip_reset low exactly 20 cycles, tx 0x54, timed_out=1, then the dump follows.
- Bad command and dropped bytes:
  - Stimulus: byte 0x7A in IDLE.
  - Response: tx 0x3F and a return to IDLE.
  - Stimulus: bytes injected during RUN/DUMP.
  - Response: no wr_pm, and no state change caused by them.
- Edge cases:
  - Stimulus: N=0x00.
  - Response: 256 writes at addrs 0..255.
  - Stimulus: halt and timeout in the same cycle.
  - Response: 0x48.
  - Stimulus: reset asserted after 1 of 3 load words.
  - Response: all outputs at reset values. The next 0x52 runs normally.
